// File: rtl/vdf_carry_pkg.sv
// vdf_carry_pkg
// Shared types and helpers for the serial carry-resolve stage.
//   cr_state_t    : control states (idle, iterating the chunk adder, holding the result)
//   cr_numchunks  : number of adder passes needed for a bw-bit word in cw-bit slices
package vdf_carry_pkg;

  typedef enum logic [1:0] {
    CR_IDLE = 2'd0,
    CR_ADD  = 2'd1,
    CR_HOLD = 2'd2
  } cr_state_t;

  function automatic int cr_numchunks(int bw, int cw);
    return (bw + cw - 1) / cw;
  endfunction

endpackage

// File: rtl/carry_resolve_serial_chunk_adder_cin.sv
// chunk_adder_cin
// One CW-bit adder slice with a registered carry that links successive passes.
// Kept on its own so the carry chain maps cleanly onto DSP/carry primitives.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear the carry (start of a new operation), wins over en
//   en         : capture the carry out of the current pass
//   a_in, b_in : operand slices
//   sum_out    : a_in + b_in + carry_q, CW+1 bits (MSB is the slice carry out)
//   carry_q    : carry into the current pass
module chunk_adder_cin #(
  parameter int CW = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] a_in,
  input  logic [CW-1:0] b_in,
  output logic [CW:0]   sum_out,
  output logic          carry_q
);

  logic carry_d;

  // Slice sum including the carry from the previous pass.
  always_comb begin
    sum_out = {1'b0, a_in} + {1'b0, b_in} + {{CW{1'b0}}, carry_q};
  end

  // Next carry: cleared per operation, updated on every adding pass.
  always_comb begin
    if (clr) begin
      carry_d = 1'b0;
    end else if (en) begin
      carry_d = sum_out[CW];
    end else begin
      carry_d = carry_q;
    end
  end

  // Carry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else begin
      carry_q <= carry_d;
    end
  end

endmodule

// File: rtl/carry_resolve_serial.sv
// carry_resolve_serial
// Resolves the two partial words of the dual-output converter into one integer,
// data_out = (data_in + dataaux_in) mod 2^BITWIDTH, using a single CHUNKBITWIDTH
// adder iterated NUMCHUNKS times. One operation in flight; result held until taken.
// Optional build macro: CARRY_RESOLVE_EARLYOUT_EN -- finish early once the carry is
// zero and the remaining aux bits are all zero (remaining data copied through).
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake
//   data_in, dataaux_in   : partial words (aux is two's complement mod 2^BITWIDTH)
//   out_valid / out_ready : result handshake
//   data_out, carry_out   : resolved sum and carry out of bit BITWIDTH-1
//   busy                  : high while the adder is iterating
module carry_resolve_serial
  import vdf_carry_pkg::*;
#(
  parameter int BITWIDTH      = 1056,
  parameter int CHUNKBITWIDTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] data_in,
  input  logic [BITWIDTH-1:0] dataaux_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] data_out,
  output logic                carry_out,
  output logic                busy
);

  localparam int NUMCHUNKS = cr_numchunks(BITWIDTH, CHUNKBITWIDTH);
  localparam int PADW      = NUMCHUNKS * CHUNKBITWIDTH;
  // Valid bits in the top slice (1..CHUNKBITWIDTH); its carry is sum bit LASTBITS.
  localparam int LASTBITS  = BITWIDTH - (NUMCHUNKS - 1) * CHUNKBITWIDTH;
  localparam int CNTW      = (NUMCHUNKS > 1) ? $clog2(NUMCHUNKS) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NUMCHUNKS - 1);

  cr_state_t           state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [PADW-1:0]     data_sh_q, data_sh_d;
  logic [PADW-1:0]     aux_sh_q, aux_sh_d;
  logic [PADW-1:0]     res_sh_q, res_sh_d;
  logic [BITWIDTH-1:0] data_out_q, data_out_d;
  logic                carry_out_q, carry_out_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic                     accept_s;
  logic                     add_en_s;
  logic [CHUNKBITWIDTH:0]   sum_s;
  logic                     carry_s;
  logic [PADW-1:0]          res_shift_s;
  logic                     finish_s;
  logic [BITWIDTH-1:0]      fin_data_s;
  logic                     fin_carry_s;
  logic                     unused_ok_s;

  chunk_adder_cin #(.CW(CHUNKBITWIDTH)) u_adder (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept_s),
    .en      (add_en_s),
    .a_in    (data_sh_q[CHUNKBITWIDTH-1:0]),
    .b_in    (aux_sh_q[CHUNKBITWIDTH-1:0]),
    .sum_out (sum_s),
    .carry_q (carry_s)
  );

  // Result shifter: the new slice enters at the top, so slice 0 ends at the bottom.
  always_comb begin
    res_shift_s = res_sh_q >> CHUNKBITWIDTH;
    res_shift_s[PADW-1 -: CHUNKBITWIDTH] = sum_s[CHUNKBITWIDTH-1:0];
  end

`ifdef CARRY_RESOLVE_EARLYOUT_EN
  logic            aux_zero_q, aux_zero_d;
  logic [PADW-1:0] early_res_s;

  // Zero flag for the aux bits not yet consumed, tracked one slice at a time.
  always_comb begin
    if (accept_s) begin
      aux_zero_d = ~|dataaux_in;
    end else if (add_en_s) begin
      aux_zero_d = ~|(aux_sh_q >> CHUNKBITWIDTH);
    end else begin
      aux_zero_d = aux_zero_q;
    end
  end

  // Aux zero flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aux_zero_q <= 1'b0;
    end else begin
      aux_zero_q <= aux_zero_d;
    end
  end

  // Early result: finished slices pulled down to the bottom, untouched data above them.
  always_comb begin
    early_res_s = (res_sh_q >> ((NUMCHUNKS - int'(cnt_q)) * CHUNKBITWIDTH))
                | (data_sh_q << (int'(cnt_q) * CHUNKBITWIDTH));
  end

  // Completion decision: early exit when nothing can change the remaining data.
  always_comb begin
    if (aux_zero_q && !carry_s) begin
      finish_s    = 1'b1;
      fin_data_s  = early_res_s[BITWIDTH-1:0];
      fin_carry_s = 1'b0;
    end else begin
      finish_s    = (cnt_q == LAST_CNT);
      fin_data_s  = res_shift_s[BITWIDTH-1:0];
      fin_carry_s = sum_s[LASTBITS];
    end
  end

  assign unused_ok_s = ^{sum_s, early_res_s};
`else
  // Completion decision: fixed number of passes.
  always_comb begin
    finish_s    = (cnt_q == LAST_CNT);
    fin_data_s  = res_shift_s[BITWIDTH-1:0];
    fin_carry_s = sum_s[LASTBITS];
  end

  assign unused_ok_s = ^sum_s;
`endif

  // Control: next state, operand/result shifting and output registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_sh_d   = data_sh_q;
    aux_sh_d    = aux_sh_q;
    res_sh_d    = res_sh_q;
    data_out_d  = data_out_q;
    carry_out_d = carry_out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    accept_s    = 1'b0;
    add_en_s    = 1'b0;
    case (state_q)
      CR_IDLE: begin
        if (in_valid && in_ready_q) begin
          accept_s   = 1'b1;
          data_sh_d  = PADW'(data_in);
          aux_sh_d   = PADW'(dataaux_in);
          cnt_d      = {CNTW{1'b0}};
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CR_ADD;
        end else begin
          in_ready_d = 1'b1;
          state_d    = CR_IDLE;
        end
      end
      CR_ADD: begin
        add_en_s  = 1'b1;
        data_sh_d = data_sh_q >> CHUNKBITWIDTH;
        aux_sh_d  = aux_sh_q >> CHUNKBITWIDTH;
        res_sh_d  = res_shift_s;
        cnt_d     = cnt_q + CNTW'(1'b1);
        if (finish_s) begin
          data_out_d  = fin_data_s;
          carry_out_d = fin_carry_s;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = CR_HOLD;
        end else begin
          state_d = CR_ADD;
        end
      end
      CR_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = CR_IDLE;
        end else begin
          state_d = CR_HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = CR_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CR_IDLE;
      cnt_q       <= {CNTW{1'b0}};
      data_sh_q   <= {PADW{1'b0}};
      aux_sh_q    <= {PADW{1'b0}};
      res_sh_q    <= {PADW{1'b0}};
      data_out_q  <= {BITWIDTH{1'b0}};
      carry_out_q <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_sh_q   <= data_sh_d;
      aux_sh_q    <= aux_sh_d;
      res_sh_q    <= res_sh_d;
      data_out_q  <= data_out_d;
      carry_out_q <= carry_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign carry_out = carry_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_carry_resolve_serial.sv
// Bench for carry_resolve_serial: a 16-bit/4-bit instance driven through a
// scoreboard (expected sums pushed at accept, popped by a monitor thread whenever
// out_valid is seen) and an 18-bit/4-bit instance covering the partial top slice.
module tb_carry_resolve_serial;

  typedef struct {
    logic [15:0] d;
    logic        c;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_carry_out, a_busy;
  logic [15:0] a_data_in, a_aux_in, a_data_out;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_carry_out, b_busy;
  logic [17:0] b_data_in, b_aux_in, b_data_out;

  int   cyc = 0;
  int   n_chk, n_fail;
  exp_t sb_q[$];
  bit   pend;
  logic [15:0] cap_d;
  logic        cap_c;
  int   last_hs, acc_cyc;
  bit   rand_ready, forced_ready;

  carry_resolve_serial #(.BITWIDTH(16), .CHUNKBITWIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .data_in(a_data_in), .dataaux_in(a_aux_in), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .data_out(a_data_out), .carry_out(a_carry_out), .busy(a_busy)
  );

  carry_resolve_serial #(.BITWIDTH(18), .CHUNKBITWIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .dataaux_in(b_aux_in), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .data_out(b_data_out), .carry_out(b_carry_out), .busy(b_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  task automatic monitor_a();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (a_out_valid) begin
        if (!pend) begin
          if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got 0x%0h with nothing outstanding", a_data_out);
          end else begin
            e = sb_q.pop_front();
            chk("sum", 32'(a_data_out), 32'(e.d));
            chk("carry_out", 32'(a_carry_out), 32'(e.c));
            chk("latency", 32'(cyc - e.acc), 32'd5);
          end
          pend  = 1'b1;
          cap_d = a_data_out;
          cap_c = a_carry_out;
        end else begin
          chk("hold_data", 32'(a_data_out), 32'(cap_d));
          chk("hold_carry", 32'(a_carry_out), 32'(cap_c));
        end
        chk("in_ready_while_valid", 32'(a_in_ready), 32'd0);
        if (a_out_ready) begin
          pend    = 1'b0;
          last_hs = cyc;
        end
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge clk);
      #2;
      a_out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
    end
  endtask

  task automatic start_a(input logic [15:0] d, input logic [15:0] a);
    a_data_in  = d;
    a_aux_in   = a;
    a_in_valid = 1'b1;
  endtask

  // Waits for the handshake; the expected result is queued when it is seen.
  task automatic wait_acc_a();
    bit          done = 1'b0;
    exp_t        e;
    int unsigned s;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (a_in_ready && rst_n) begin
        s     = int'(a_data_in) + int'(a_aux_in);
        e.d   = 16'(s % 65536);
        e.c   = (s >= 65536);
        e.acc = cyc;
        sb_q.push_back(e);
        acc_cyc = cyc;
        done    = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    a_in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready never seen, expected within 100 cycles");
    end
  endtask

  task automatic send_a(input logic [15:0] d, input logic [15:0] a);
    start_a(d, a);
    wait_acc_a();
  endtask

  task automatic drain_a();
    for (int i = 0; i < 300 && (sb_q.size() != 0 || pend); i++) begin
      @(posedge clk);
    end
    #1;
    if (sb_q.size() != 0 || pend) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  // Single transaction on the 18-bit instance, checked inline.
  task automatic run_b(input logic [17:0] d, input logic [17:0] a);
    int unsigned s;
    int          acc = -1;
    bit          seen = 1'b0;
    s = int'(d) + int'(a);
    b_data_in  = d;
    b_aux_in   = a;
    b_in_valid = 1'b1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clk);
      if (b_in_ready) acc = cyc;
    end
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (b_out_valid) begin
        seen = 1'b1;
        chk("b_sum", 32'(b_data_out), 32'(s % 262144));
        chk("b_carry_out", 32'(b_carry_out), 32'(s >= 262144));
        chk("b_latency", 32'(cyc - acc), 32'd6);
      end
    end
    if (!seen || acc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL b_timeout: no result for 0x%0h + 0x%0h", d, a);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] d, a;
    n_chk = 0; n_fail = 0; pend = 1'b0; last_hs = 0; acc_cyc = 0;
    rand_ready = 1'b0; forced_ready = 1'b1;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_data_in = 16'h0; a_aux_in = 16'h0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_data_in = 18'h0; b_aux_in = 18'h0; b_out_ready = 1'b1;
    fork
      monitor_a();
      ready_drv();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_data_out", 32'(a_data_out), 32'd0);
    chk("rst_carry_out", 32'(a_carry_out), 32'd0);
    chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed sums: carry ripple, negative aux, full wrap, zero.
    send_a(16'h00FF, 16'h0001);
    send_a(16'h1234, 16'hFFF0);
    send_a(16'hFFFF, 16'h0001);
    send_a(16'h0000, 16'h0000);
    send_a(16'h0010, 16'hFFE0);
    drain_a();

    // Backpressure: seven stalled cycles with a new request waiting.
    forced_ready = 1'b0;
    send_a(16'hA5A5, 16'h0F0F);
    for (int i = 0; i < 50 && !a_out_valid; i++) @(negedge clk);
    @(posedge clk);
    #1;
    start_a(16'h0102, 16'h0304);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_in_ready", 32'(a_in_ready), 32'd0);
    forced_ready = 1'b1;
    wait_acc_a();
    chk("accept_after_release", 32'(acc_cyc), 32'(last_hs + 1));
    drain_a();

    // Reset on the third adding cycle.
    send_a(16'h5555, 16'h3333);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("busy_in_add", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_data_out", 32'(a_data_out), 32'd0);
    chk("mid_rst_carry_out", 32'(a_carry_out), 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_a(16'h0001, 16'h0001);
    drain_a();

    // Random operands with random consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      d = 16'($urandom);
      a = 16'($urandom);
      case ($urandom_range(0, 5))
        0: a = 16'(17'h10000 - 17'(d));
        1: d = 16'hFFFF;
        2: a = 16'hFFFF;
        default: ;
      endcase
      send_a(d, a);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    drain_a();

    // Partial top slice on the 18-bit instance.
    run_b(18'h3FFFF, 18'h00001);
    run_b(18'h20000, 18'h20000);
    run_b(18'h1FFFF, 18'h00001);
    for (int i = 0; i < 100; i++) begin
      run_b(18'($urandom), 18'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
